// File: rtl/lsu_mem_stage_pkg.sv
// Shared definitions for the memory-stage load/store unit.
package lsu_mem_stage_pkg;

  localparam logic [2:0] LSU_F3_B  = 3'b000;
  localparam logic [2:0] LSU_F3_H  = 3'b001;
  localparam logic [2:0] LSU_F3_W  = 3'b010;
  localparam logic [2:0] LSU_F3_BU = 3'b100;
  localparam logic [2:0] LSU_F3_HU = 3'b101;

  typedef enum logic [1:0] {
    LSU_ST_IDLE = 2'd0,
    LSU_ST_REQ  = 2'd1,
    LSU_ST_RESP = 2'd2
  } lsu_state_e;

  typedef enum logic [1:0] {
    LSU_CAUSE_NONE     = 2'd0,
    LSU_CAUSE_MISALIGN = 2'd1,
    LSU_CAUSE_TIMEOUT  = 2'd2
  } lsu_cause_e;

  // funct3 encodings with no load/store meaning, plus unsigned stores
  function automatic logic lsu_f3_illegal(input logic we, input logic [2:0] f3);
    logic bad;
    bad = (f3 == 3'b011) || (f3[2:1] == 2'b11) || (we && f3[2]);
    return bad;
  endfunction

endpackage

// File: rtl/lsu_mem_stage_align.sv
// Lane formatting: byte enables, store replication, load extraction/extension.
module lsu_align
  import lsu_mem_stage_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        misaligned_o
);

  logic [31:0] shifted;

  // Size-dependent byte enables, store lane replication and alignment check
  always_comb begin
    be_o         = 4'b1111;
    wdata_o      = wdata_i;
    misaligned_o = 1'b0;
    case (funct3_i[1:0])
      2'b00: begin
        be_o    = 4'b0001 << addr_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        be_o         = 4'b0011 << {addr_i[1], 1'b0};
        wdata_o      = {2{wdata_i[15:0]}};
        misaligned_o = addr_i[0];
      end
      default: begin
        be_o         = 4'b1111;
        wdata_o      = wdata_i;
        misaligned_o = (addr_i != 2'b00);
      end
    endcase
  end

  // Shift the addressed lane down and extend it to 32 bits
  always_comb begin
    shifted = rdata_i >> {addr_i, 3'b000};
    case (funct3_i)
      LSU_F3_B:  rdata_o = {{24{shifted[7]}}, shifted[7:0]};
      LSU_F3_H:  rdata_o = {{16{shifted[15]}}, shifted[15:0]};
      LSU_F3_BU: rdata_o = {24'h0, shifted[7:0]};
      LSU_F3_HU: rdata_o = {16'h0, shifted[15:0]};
      default:   rdata_o = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// Memory-stage load/store unit: one bus transaction per accepted request.
module lsu_mem_stage
  import lsu_mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic [1:0]  resp_cause_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  lsu_state_e  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  lsu_cause_e  cause_q, cause_d;

  logic [2:0]  al_f3;
  logic [1:0]  al_off;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_rdata;
  logic        al_mis;

  // One formatter serves both phases: request fields in IDLE, latched fields after
  always_comb begin
    al_f3  = (state_q == LSU_ST_IDLE) ? req_funct3_i : f3_q;
    al_off = (state_q == LSU_ST_IDLE) ? req_addr_i[1:0] : off_q;
  end

  lsu_align u_align (
    .funct3_i     (al_f3),
    .addr_i       (al_off),
    .wdata_i      (req_wdata_i),
    .rdata_i      (mem_rdata_i),
    .be_o         (al_be),
    .wdata_o      (al_wdata),
    .rdata_o      (al_rdata),
    .misaligned_o (al_mis)
  );

  // Next-state, latch and timeout logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    f3_d    = f3_q;
    off_d   = off_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cause_d = cause_q;
    case (state_q)
      LSU_ST_IDLE: begin
        if (req_valid_i) begin
          we_d    = req_we_i;
          f3_d    = req_funct3_i;
          off_d   = req_addr_i[1:0];
          addr_d  = {req_addr_i[31:2], 2'b00};
          be_d    = al_be;
          wdata_d = al_wdata;
          rdata_d = '0;
          cnt_d   = '0;
          if (al_mis || lsu_f3_illegal(req_we_i, req_funct3_i)) begin
            state_d = LSU_ST_RESP;
            err_d   = 1'b1;
            cause_d = LSU_CAUSE_MISALIGN;
          end else begin
            state_d = LSU_ST_REQ;
            err_d   = 1'b0;
            cause_d = LSU_CAUSE_NONE;
          end
        end
      end
      LSU_ST_REQ: begin
        // ack is tested first so it wins over a coincident timeout
        if (mem_ack_i) begin
          state_d = LSU_ST_RESP;
          rdata_d = we_q ? '0 : al_rdata;
          cnt_d   = '0;
        end else if (cnt_q == TO_LAST) begin
          state_d = LSU_ST_RESP;
          err_d   = 1'b1;
          cause_d = LSU_CAUSE_TIMEOUT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      LSU_ST_RESP: begin
        state_d = LSU_ST_IDLE;
        err_d   = 1'b0;
        cause_d = LSU_CAUSE_NONE;
        rdata_d = '0;
      end
      default: state_d = LSU_ST_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= LSU_ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      off_q   <= '0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cause_q <= LSU_CAUSE_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cause_q <= cause_d;
    end
  end

  // Output decode
  always_comb begin
    req_ready_o  = (state_q == LSU_ST_IDLE);
    mem_req_o    = (state_q == LSU_ST_REQ);
    resp_valid_o = (state_q == LSU_ST_RESP);
    resp_rdata_o = rdata_q;
    resp_err_o   = err_q;
    resp_cause_o = cause_q;
    mem_we_o     = we_q;
    mem_addr_o   = addr_q;
    mem_be_o     = be_q;
    mem_wdata_o  = wdata_q;
  end

endmodule
